// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the interrupt vector sequencer
package intr_pkg;

  // Service FSM states
  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  // Default base vector number added to the encoder code
  localparam logic [7:0] VEC_BASE_DFLT = 8'h20;

  // Width of the priority encoder code (8 request lines)
  localparam int CODE_W = 3;

endpackage

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit saturating counter with enable and synchronous clear
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] q
);

  // Reset and clear dominate; otherwise count up and stick at 255
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 8'h00;
    end else if (en && (q != 8'hFF)) begin
      q <= q + 8'h01;
    end
  end

endmodule

// File: rtl/intr_vec_sequencer.sv
// rtl/intr_vec_sequencer.sv - interrupt vector sequencer; optional ack timeout under INTR_TIMEOUT_EN
module intr_vec_sequencer
  import intr_pkg::*;
#(
  parameter logic [7:0] VEC_BASE    = VEC_BASE_DFLT,
  parameter int         TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CODE_W-1:0] A,
  input  logic              IDLE,
  input  logic              ACK,
  output logic              VALID,
  output logic [7:0]        VEC,
  output logic [7:0]        CLR,
  output logic [7:0]        SVC_CNT,
  output logic              TOUT
);

  state_t            state;
  state_t            state_nx;
  logic [CODE_W-1:0] code;
  logic              svc_inc;
  logic              tmo_fire;

  // A finished service is exactly a PRESENT->CLEAR transition
  assign svc_inc = (state == PRESENT) && ACK;

`ifdef INTR_TIMEOUT_EN
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tcnt;

  // Counts cycles spent in PRESENT; restarts on every PRESENT entry
  sat_counter8 u_tmo_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr ((state == WAIT) && !IDLE),
    .en  (state == PRESENT),
    .q   (tcnt)
  );

  // Expiry on the last allowed PRESENT cycle; a same-cycle ACK wins
  assign tmo_fire = (state == PRESENT) && (tcnt == TLAST) && !ACK;
`else
  assign tmo_fire = 1'b0;
`endif

  sat_counter8 u_svc_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (1'b0),
    .en  (svc_inc),
    .q   (SVC_CNT)
  );

  // Next-state logic; A and IDLE are ignored once a vector is presented
  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (!IDLE) state_nx = PRESENT;
      PRESENT: begin
        if (ACK)           state_nx = CLEAR;
        else if (tmo_fire) state_nx = WAIT;
      end
      CLEAR:   state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // State, code capture and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= WAIT;
      code  <= '0;
      VALID <= 1'b0;
      VEC   <= 8'h00;
      CLR   <= 8'h00;
      TOUT  <= 1'b0;
    end else begin
      state <= state_nx;
      VALID <= (state_nx == PRESENT);
      CLR   <= (state_nx == CLEAR) ? (8'h01 << code) : 8'h00;
      TOUT  <= tmo_fire;
      if ((state == WAIT) && !IDLE) begin
        code <= A;
        VEC  <= VEC_BASE + {5'b00000, A};
      end
    end
  end

endmodule

// File: tb/tb_intr_vec_sequencer.sv
// tb/tb_intr_vec_sequencer.sv - directed self-checking bench for intr_vec_sequencer
module tb_intr_vec_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] a;
  logic       idle;
  logic       ack;

  logic       valid0, tout0;
  logic [7:0] vec0, clr0, svc0;
  logic       valid1, tout1;
  logic [7:0] vec1, clr1, svc1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  intr_vec_sequencer u_dut (
    .CLK(clk), .RESET(reset), .A(a), .IDLE(idle), .ACK(ack),
    .VALID(valid0), .VEC(vec0), .CLR(clr0), .SVC_CNT(svc0), .TOUT(tout0)
  );

  intr_vec_sequencer #(.VEC_BASE(8'hFC), .TIMEOUT_CYC(4)) u_dut_fc (
    .CLK(clk), .RESET(reset), .A(a), .IDLE(idle), .ACK(ack),
    .VALID(valid1), .VEC(vec1), .CLR(clr1), .SVC_CNT(svc1), .TOUT(tout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle = 1'b1; ack = 1'b0; a = 3'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  int clr_ok;
  int tout_cnt;

  initial begin
    reset = 1'b1; idle = 1'b1; ack = 1'b0; a = 3'd0;

    // Reset state
    do_reset();
    check("rst_valid", valid0, 1'b0);
    check("rst_vec",   vec0,   8'h00);
    check("rst_clr",   clr0,   8'h00);
    check("rst_svc",   svc0,   8'h00);
    check("rst_tout",  tout0,  1'b0);

    // Basic service, ACK on second PRESENT cycle
    idle = 1'b0; a = 3'd5;
    tick();
    check("basic_valid1", valid0, 1'b1);
    check("basic_vec1",   vec0,   8'h25);
    tick();
    check("basic_valid2", valid0, 1'b1);
    ack = 1'b1; idle = 1'b1;
    tick();
    check("basic_valid_clr", valid0, 1'b0);
    check("basic_clr",       clr0,   8'h20);
    check("basic_svc",       svc0,   8'h01);
    ack = 1'b0;
    tick();
    check("basic_clr_gone", clr0, 8'h00);

    // No preemption by a higher-priority request
    idle = 1'b0; a = 3'd2;
    tick();
    check("nopre_vec1", vec0, 8'h22);
    a = 3'd7;
    tick();
    check("nopre_vec2", vec0, 8'h22);
    ack = 1'b1; idle = 1'b1;
    tick();
    check("nopre_clr", clr0, 8'h04);
    check("nopre_svc", svc0, 8'h02);
    ack = 1'b0;
    tick();

    // ACK in WAIT is ignored
    ack = 1'b1;
    tick();
    check("waitack_valid", valid0, 1'b0);
    check("waitack_clr",   clr0,   8'h00);
    check("waitack_svc",   svc0,   8'h02);
    ack = 1'b0;

    // Vector base wrap-around
    idle = 1'b0; a = 3'd6;
    tick();
    check("wrap_vec_fc", vec1, 8'h02);
    check("wrap_vec_20", vec0, 8'h26);
    ack = 1'b1; idle = 1'b1;
    tick();
    check("wrap_clr", clr1, 8'h40);
    ack = 1'b0;
    tick();

    // Reset mid-PRESENT with ACK in the same cycle
    idle = 1'b0; a = 3'd3;
    tick();
    check("rstpre_valid_pre", valid0, 1'b1);
    reset = 1'b1; ack = 1'b1;
    tick();
    check("rstpre_valid", valid0, 1'b0);
    check("rstpre_clr",   clr0,   8'h00);
    check("rstpre_svc",   svc0,   8'h00);
    reset = 1'b0; ack = 1'b0; idle = 1'b1;
    tick();
    check("rstpre_clr_after", clr0, 8'h00);
    check("rstpre_svc_after", svc0, 8'h00);

    // 300 back-to-back services: counter saturates, every CLR seen
    do_reset();
    clr_ok = 0;
    ack = 1'b1; idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a = 3'(i % 8);
      tick();
      tick();
      if (clr0 == (8'h01 << (i % 8))) clr_ok++;
      tick();
    end
    check("sat_clr_count", clr_ok, 300);
    check("sat_svc",       svc0,   8'hFF);
    check("sat_svc_fc",    svc1,   8'hFF);
    for (int i = 0; i < 6; i++) tick();
    check("sat_svc_hold",  svc0,   8'hFF);
    ack = 1'b0; idle = 1'b1;
    tick(); tick(); tick();

`ifdef INTR_TIMEOUT_EN
    // Acknowledge timeout on the TIMEOUT_CYC=4 instance
    do_reset();
    idle = 1'b0; a = 3'd1; ack = 1'b0;
    tick();
    check("tmo_valid_entry", valid1, 1'b1);
    check("tmo_vec_entry",   vec1,   8'hFD);
    tout_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_valid_hold", valid1, 1'b1);
      if (tout1) tout_cnt++;
    end
    tick();
    check("tmo_valid_drop", valid1, 1'b0);
    check("tmo_tout",       tout1,  1'b1);
    check("tmo_clr",        clr1,   8'h00);
    check("tmo_svc",        svc1,   8'h00);
    tick();
    if (tout1) tout_cnt++;
    check("tmo_tout_once",  tout_cnt, 0);
    check("tmo_represent",  valid1, 1'b1);
    check("tmo_revec",      vec1,   8'hFD);
    idle = 1'b1;
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_vec_sequencer.md
INTR_VEC_SEQUENCER -- requirements
Module: intr_vec_sequencer

Interface
REQ-001 Parameter VEC_BASE, default 8'h20, base vector number added to the encoder code.
REQ-002 Parameter TIMEOUT_CYC, default 16, acknowledge timeout in cycles; used only when INTR_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 Ports SHALL be, in this order:
- CLK, input, 1 bit: the single clock.
- RESET, input, 1 bit: synchronous, active-high reset.
- A, input, 3 bits: highest-priority active request index, from the 8-input priority encoder.
- IDLE, input, 1 bit: encoder idle flag; 1 means no request is active.
- ACK, input, 1 bit: consumer accepts the presented vector.
- VALID, output, 1 bit: a vector is being presented.
- VEC, output, 8 bits: interrupt vector number.
- CLR, output, 8 bits: one-hot clear pulse back to the request latch.
- SVC_CNT, output, 8 bits: count of completed services.
- TOUT, output, 1 bit: one-cycle pulse on acknowledge timeout.
REQ-004 All outputs SHALL be driven from registers; no combinational path from any input to any output.

Function
REQ-005 FSM SHALL have exactly three states: WAIT, PRESENT, CLEAR.
REQ-006 WAIT, IDLE==1: remain in WAIT.
REQ-007 WAIT, IDLE==0: register A into the internal code register and go to PRESENT; VALID rises at that same edge (1-cycle latency from IDLE low).
REQ-008 VEC SHALL equal (VEC_BASE + code) mod 256, as an 8-bit wrap-around add, and is registered at the PRESENT entry edge.
REQ-009 PRESENT: VALID=1 and VEC held constant; A and IDLE are ignored (no preemption by a higher-priority request, no abort if IDLE rises).
REQ-010 PRESENT, ACK==1: go to CLEAR at the next edge; VALID falls at that edge.
REQ-011 CLEAR: CLR = 1 << code for exactly one cycle, VALID=0; unconditionally go to WAIT at the next edge.
REQ-012 SVC_CNT SHALL increment by 1 on every PRESENT->CLEAR transition and saturate at 255, never wrapping.
REQ-013 ACK received in WAIT or CLEAR SHALL be ignored.
REQ-014 CLR SHALL be 8'h00 in every state other than CLEAR.
REQ-015 Minimum service cadence is 3 cycles (WAIT, PRESENT, CLEAR), so the encoder sees the cleared latch before the next WAIT sample.
REQ-016 After RESET deasserts, the block SHALL be in WAIT and sample IDLE on the first clock edge.

Reset
REQ-017 RESET SHALL be synchronous and active-high; it is sampled only on the rising edge of CLK.
REQ-018 On reset: state=WAIT, VALID=0, VEC=8'h00, CLR=8'h00, SVC_CNT=8'h00, TOUT=0, code=3'b000, timeout counter=0.
REQ-019 Reset asserted during PRESENT or CLEAR SHALL abort the service: no CLR pulse and no SVC_CNT increment afterwards.
REQ-020 RESET SHALL take priority over ACK and IDLE in the same cycle.

Configuration
REQ-021 Macro INTR_TIMEOUT_EN.
REQ-022 When INTR_TIMEOUT_EN is defined:
- An 8-bit counter SHALL clear on PRESENT entry and increment once per cycle spent in PRESENT.
- If the counter reaches TIMEOUT_CYC with ACK==0, the FSM SHALL go to WAIT with no CLR pulse and no SVC_CNT change, and TOUT SHALL pulse for one cycle.
- The request stays pending and is re-presented from WAIT.
REQ-023 When INTR_TIMEOUT_EN is defined and ACK==1 in the expiry cycle, ACK SHALL win: normal CLEAR, TOUT stays 0.
REQ-024 When INTR_TIMEOUT_EN is undefined: the TOUT port still exists, tied to 0; PRESENT waits for ACK indefinitely; no counter logic is synthesized.

Structure
REQ-025 Shared package intr_pkg SHALL hold the state typedef (WAIT/PRESENT/CLEAR), the 8'h20 default vector base, and the 3-bit code width constant.
REQ-026 One sub-module, sat_counter8 (8-bit, enable, synchronous clear, saturating), SHALL be used for SVC_CNT and reused for the timeout counter.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Basic service: RESET 2 cycles, then IDLE=0, A=3'd5, ACK high on the 2nd PRESENT cycle -> VALID=1, VEC=8'h25; then CLR=8'h20 for one cycle, SVC_CNT=1.
- No preemption: during PRESENT with A=2, drive A=7 -> VEC stays 8'h22; on ACK, CLR=8'h04.
- Wrap: VEC_BASE=8'hFC, A=6 -> VEC=8'h02.
- Saturation: 300 back-to-back services -> SVC_CNT=255 and held; no CLR missed.
- Timeout (INTR_TIMEOUT_EN defined, TIMEOUT_CYC=4, ACK never asserted) -> VALID drops after 4 PRESENT cycles, TOUT pulses once, CLR=0, same VEC re-presented.
- Reset mid-PRESENT with ACK=1 in the same cycle -> VALID=0, CLR=0, SVC_CNT unchanged at the next edge.
